// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder slice; also exposes the carry into its MSB for overflow detection.
module digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[DIGIT];
    assign cmsb_o = carry[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock, LSB digit first.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             OV
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = cnt_width(N);

    if ((DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
        $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ov_q, ov_d;

    logic             accept_c;
    logic             last_c;
    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic             dcmsb;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a_i    (a_q[DIGIT-1:0]),
        .b_i    (b_q[DIGIT-1:0]),
        .cin_i  (carry_q),
        .sum_o  (dsum),
        .cout_o (dcout),
        .cmsb_o (dcmsb)
    );

    assign accept_c = (state_q != RUN) && start;
    assign last_c   = (state_q == RUN) && (cnt_q == CW'(N - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start during RUN is deliberately ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: state_d = start ? RUN : IDLE;
            RUN:        state_d = last_c ? DONE : RUN;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ov_d    = ov_q;
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);

        if (accept_c) begin
            a_d     = A;
            b_d     = sub ? ~B : B;
            carry_d = sub ? 1'b1 : Cin;
            cnt_d   = '0;
            res_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            res_d   = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
            carry_d = dcout;
            cnt_d   = CW'(cnt_q + CW'(1));
            if (last_c) begin
                s_d    = res_d;
                cout_d = dcout;
                ov_d   = dcmsb ^ dcout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ov_q    <= ov_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
    assign OV   = ov_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: behavioural model, per-cycle compare, directed and random ops.
module tb_digit_serial_adder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIGIT = 4;
    localparam int unsigned N     = WIDTH / DIGIT;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ov;

    int n_tests = 0;
    int n_fail  = 0;

    digit_serial_adder #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .busy  (busy),
        .done  (done),
        .S     (s),
        .Cout  (cout),
        .OV    (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic: returns {ov, cout, sum}.
    function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic ci, input logic sb);
        logic [WIDTH-1:0] yy;
        logic [WIDTH:0]   full;
        logic             o;
        yy   = sb ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, (sb ? 1'b1 : ci)};
        o    = (x[WIDTH-1] == yy[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        return {o, full[WIDTH], full[WIDTH-1:0]};
    endfunction

    // Behavioural model: an op occupies N cycles after acceptance, then publishes its result.
    int               m_left;
    logic             m_busy, m_done, m_c, m_ov;
    logic [WIDTH-1:0] m_s;
    logic [WIDTH+1:0] m_pending;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_busy = 0; m_done = 0; m_s = '0; m_c = 0; m_ov = 0; m_pending = '0;
        end else begin
            m_done = 0;
            if (m_left != 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    {m_ov, m_c, m_s} = m_pending;
                    m_done = 1;
                end
            end else if (start) begin
                m_left    = N;
                m_pending = ref_op(a, b, cin, sub);
            end
            m_busy = (m_left != 0);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        n_tests++;
        if (busy !== m_busy || done !== m_done || s !== m_s || cout !== m_c || ov !== m_ov) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t: got busy=%b done=%b S=%h Cout=%b OV=%b, want busy=%b done=%b S=%h Cout=%b OV=%b",
                     $time, busy, done, s, cout, ov, m_busy, m_done, m_s, m_c, m_ov);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic set_ops(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci, input logic sb);
        a = x; b = y; cin = ci; sub = sb;
    endtask

    // Waits (bounded) for done; reports cycles elapsed since call.
    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) return;
        end
        n_tests++; n_fail++;
        $display("FAIL %s_timeout: got no done after %0d cycles, want done", name, cyc);
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic ci, input logic sb,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int cyc;
        @(negedge clk);
        set_ops(x, y, ci, sb);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'd1);
        wait_done(name, cyc);
        check({name, "_lat"}, 32'(cyc), 32'(N));
        check({name, "_S"}, 32'(s), 32'(es));
        check({name, "_Cout_OV"}, {30'd0, cout, ov}, {30'd0, ec, eo});
    endtask

    initial begin
        int cyc;
        logic saw_done;
        rst = 1'b1; start = 1'b0;
        set_ops('0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_outs", {12'd0, busy, done, s, cout, ov}, 32'd0);

        run_op("add",      16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0);
        run_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("wrap_cin", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        run_op("ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub",      16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // start during RUN must be ignored.
        @(negedge clk);
        set_ops(16'h1234, 16'h0FED, 1'b0, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        set_ops(16'hAAAA, 16'h5555, 1'b1, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore", cyc);
        check("ignore_lat", 32'(cyc), 32'(N - 2));
        check("ignore_S", 32'(s), 32'h2221);

        // Async reset mid-operation aborts without done.
        @(negedge clk);
        set_ops(16'h0F0F, 16'h0101, 1'b1, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_outs", {12'd0, busy, done, s, cout, ov}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("rst_no_done", 32'(saw_done), 32'd0);

        // Back-to-back: new start accepted in the DONE cycle.
        run_op("b2b_first", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        set_ops(16'h8001, 16'h8001, 1'b0, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy_done", {30'd0, busy, done}, 32'd2);
        check("b2b_hold_S", 32'(s), 32'h3333);
        wait_done("b2b_second", cyc);
        check("b2b_lat", 32'(cyc), 32'(N));
        check("b2b_second_res", {14'd0, s, cout, ov}, {14'd0, 16'h0002, 1'b1, 1'b1});

        // Random traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            set_ops(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
            start = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        repeat (2 * N + 2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
